// File: rtl/sc_mux_scan_sequencer_if.sv
// Bundle between the mux scan sequencer and its surroundings (mux data source and word consumer).
// valid/ready: a word transfers on a rising edge where valid=1 and ready=1; while valid=1 and
// ready=0 the word, channel and select are held unchanged; valid never depends on ready combinationally.
interface sc_mux_scan_sequencer_if #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int SELECT_WIDTH     = 4
);
  logic                        start;
  logic                        continuous;
  logic                        abort;
  logic [NUMBER_DATAWIDTH-1:0] data_in;
  logic                        ready;
  logic [SELECT_WIDTH-1:0]     select;
  logic [NUMBER_DATAWIDTH-1:0] data_out;
  logic [SELECT_WIDTH-1:0]     channel;
  logic                        valid;
  logic                        busy;
  logic                        done;
  logic [1:0]                  state;

  modport master (
    input  start, continuous, abort, data_in, ready,
    output select, data_out, channel, valid, busy, done, state
  );

  modport slave (
    output start, continuous, abort, data_in, ready,
    input  select, data_out, channel, valid, busy, done, state
  );
endinterface

// File: rtl/sc_mux_scan_sequencer.sv
// Sweeps a data mux select over all channels, waits a settle interval per channel, and
// presents each captured word with its channel index over a valid/ready handshake.
module sc_mux_scan_sequencer #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int SELECT_WIDTH     = 4,
  parameter int NUM_CHANNELS     = 10,
  parameter int SETTLE_CYCLES    = 2,
  parameter int CNT_WIDTH        = 4
) (
  input  logic                  SC_MUXSEQ_CLOCK_50,
  input  logic                  SC_MUXSEQ_RESET_InHigh,
  sc_mux_scan_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [SELECT_WIDTH-1:0] LAST_SEL    = SELECT_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [SELECT_WIDTH-1:0] SEL_ONE     = SELECT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]    SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE     = CNT_WIDTH'(1);

  state_t                      state;
  logic [CNT_WIDTH-1:0]        cnt;
  logic [SELECT_WIDTH-1:0]     select_q;
  logic [NUMBER_DATAWIDTH-1:0] data_q;
  logic [SELECT_WIDTH-1:0]     channel_q;
  logic                        valid_q;
  logic                        busy_q;
  logic                        done_q;

  // Abort outranks every state transition except reset; in IDLE it also masks start.
  always_ff @(posedge SC_MUXSEQ_CLOCK_50 or posedge SC_MUXSEQ_RESET_InHigh) begin
    if (SC_MUXSEQ_RESET_InHigh) begin
      state     <= IDLE;
      cnt       <= '0;
      select_q  <= '0;
      data_q    <= '0;
      channel_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.abort) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            select_q <= '0;
            cnt      <= '0;
            busy_q   <= 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            data_q    <= bus.data_in;
            channel_q <= select_q;
            valid_q   <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (bus.ready) begin
            valid_q <= 1'b0;
            if (select_q == LAST_SEL) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              select_q <= select_q + SEL_ONE;
              cnt      <= '0;
              state    <= SETTLE;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (bus.continuous) begin
            select_q <= '0;
            cnt      <= '0;
            state    <= SETTLE;
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.select   = select_q;
  assign bus.data_out = data_q;
  assign bus.channel  = channel_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.state    = state;

endmodule
